// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the fetch-stage PC controller.
// Holds FSM states, next-PC select codes and alignment constants.
package pc_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_JR     = 2'd2,
    SEL_BRANCH = 2'd3
  } pc_sel_e;

  localparam int unsigned INSTR_INC  = 4;
  localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: prioritised next-PC mux with word-alignment masking.
// Branch beats JR beats jump beats the sequential PC.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int SIZE_ADDR_PC = 32
) (
  input  logic [SIZE_ADDR_PC-1:0] i_pc_4,
  input  logic                    i_branch_taken,
  input  logic [SIZE_ADDR_PC-1:0] i_branch_target,
  input  logic                    i_jr,
  input  logic [SIZE_ADDR_PC-1:0] i_jr_target,
  input  logic                    i_jump,
  input  logic [SIZE_ADDR_PC-1:0] i_jump_target,
  output logic [SIZE_ADDR_PC-1:0] o_next_pc,
  output pc_sel_e                 o_sel,
  output logic                    o_misaligned
);

  localparam logic [SIZE_ADDR_PC-1:0] MASK =
    SIZE_ADDR_PC'(ALIGN_MASK);

  logic [SIZE_ADDR_PC-1:0] raw;

  always_comb begin
    raw   = i_pc_4;
    o_sel = SEL_SEQ;
    priority case (1'b1)
      i_branch_taken: begin
        raw   = i_branch_target;
        o_sel = SEL_BRANCH;
      end
      i_jr: begin
        raw   = i_jr_target;
        o_sel = SEL_JR;
      end
      i_jump: begin
        raw   = i_jump_target;
        o_sel = SEL_JUMP;
      end
      default: begin
        raw   = i_pc_4;
        o_sel = SEL_SEQ;
      end
    endcase
  end

  assign o_next_pc    = raw & ~MASK;
  assign o_misaligned = |(raw & MASK);

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC owner with redirects, single-step,
// HALT/breakpoint stop states and an advance counter.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int                    SIZE_ADDR_PC = 32,
  parameter logic [SIZE_ADDR_PC-1:0] RESET_VECTOR = '0,
  parameter int                    SIZE_CNT     = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_run_mode,
  input  logic                    i_step,
  input  logic                    i_pc_write,
  input  logic                    i_branch_taken,
  input  logic [SIZE_ADDR_PC-1:0] i_branch_target,
  input  logic                    i_jr,
  input  logic [SIZE_ADDR_PC-1:0] i_jr_target,
  input  logic                    i_jump,
  input  logic [SIZE_ADDR_PC-1:0] i_jump_target,
  input  logic                    i_halt,
  input  logic                    i_restart,
  input  logic                    i_bp_en,
  input  logic [SIZE_ADDR_PC-1:0] i_bp_addr,
  output logic [SIZE_ADDR_PC-1:0] o_pc,
  output logic [SIZE_ADDR_PC-1:0] o_pc_4,
  output logic [SIZE_ADDR_PC-1:0] o_pc_8,
  output logic                    o_halted,
  output logic                    o_bp_hit,
  output logic                    o_misaligned,
  output logic [SIZE_CNT-1:0]     o_adv_count
);

  pc_state_e               state_q, state_d;
  logic [SIZE_ADDR_PC-1:0] pc_q, pc_d;
  logic [SIZE_CNT-1:0]     cnt_q, cnt_d;
  logic                    step_q;
  logic                    bp_q, bp_d;
  logic                    mis_q, mis_d;

  logic [SIZE_ADDR_PC-1:0] next_pc;
  pc_sel_e                 sel;
  logic                    mis_raw;
  logic                    step_pulse;
  logic                    adv;
  logic                    bp_stop;
  logic                    halt_stop;

  assign o_pc   = pc_q;
  assign o_pc_4 = pc_q + SIZE_ADDR_PC'(INSTR_INC);
  assign o_pc_8 = pc_q + SIZE_ADDR_PC'(2 * INSTR_INC);

  pc_next_sel #(
    .SIZE_ADDR_PC (SIZE_ADDR_PC)
  ) u_next_sel (
    .i_pc_4          (o_pc_4),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jr            (i_jr),
    .i_jr_target     (i_jr_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .o_next_pc       (next_pc),
    .o_sel           (sel),
    .o_misaligned    (mis_raw)
  );

  assign step_pulse = i_step & ~step_q;
  assign adv        = (state_q == ST_RUN) & i_pc_write
                    & (i_run_mode | step_pulse);
  assign bp_stop    = adv & i_bp_en & (pc_q == i_bp_addr);
  assign halt_stop  = adv & i_halt;

  always_comb begin
    state_d = state_q;
    if (i_restart) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:    if (bp_stop | halt_stop) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Only explicit targets can be misaligned; the sequential path is not flagged.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    bp_d  = 1'b0;
    mis_d = 1'b0;
    if (i_restart) begin
      pc_d  = RESET_VECTOR;
      cnt_d = '0;
    end else if (bp_stop) begin
      bp_d = 1'b1;
    end else if (adv && !halt_stop) begin
      pc_d  = next_pc;
      cnt_d = cnt_q + SIZE_CNT'(1);
      mis_d = mis_raw && (sel != SEL_SEQ);
    end
  end

  always_ff @(negedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // step_q resets high so a step held through reset gives no pulse.
  always_ff @(negedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q   <= RESET_VECTOR;
      cnt_q  <= '0;
      step_q <= 1'b1;
      bp_q   <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      step_q <= i_step;
      bp_q   <= bp_d;
      mis_q  <= mis_d;
    end
  end

  assign o_halted     = (state_q == ST_HALTED);
  assign o_bp_hit     = bp_q;
  assign o_misaligned = mis_q;
  assign o_adv_count  = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: scoreboard bench for pc_ctrl with a cycle-level reference
// model; directed scenarios followed by randomized traffic.
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_mode, step, pc_write;
  logic        branch, jr, jump, halt, restart, bp_en;
  logic [31:0] bt, jrt, jt, bp_addr;
  logic [31:0] pc, pc4, pc8, cnt;
  logic        halted, bp_hit, mis;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        halted;
    logic        bp;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_pc, m_cnt;
  bit          m_halted, m_bp, m_mis, m_prev_step;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_run_mode      (run_mode),
    .i_step          (step),
    .i_pc_write      (pc_write),
    .i_branch_taken  (branch),
    .i_branch_target (bt),
    .i_jr            (jr),
    .i_jr_target     (jrt),
    .i_jump          (jump),
    .i_jump_target   (jt),
    .i_halt          (halt),
    .i_restart       (restart),
    .i_bp_en         (bp_en),
    .i_bp_addr       (bp_addr),
    .o_pc            (pc),
    .o_pc_4          (pc4),
    .o_pc_8          (pc8),
    .o_halted        (halted),
    .o_bp_hit        (bp_hit),
    .o_misaligned    (mis),
    .o_adv_count     (cnt)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    logic [31:0] e4, e8;
    e4 = e.pc + 32'd4;
    e8 = e.pc + 32'd8;
    check("pc", 64'(pc), 64'(e.pc));
    check("pc_4", 64'(pc4), 64'(e4));
    check("pc_8", 64'(pc8), 64'(e8));
    check("adv_count", 64'(cnt), 64'(e.cnt));
    check("halted", 64'(halted), 64'(e.halted));
    check("bp_hit", 64'(bp_hit), 64'(e.bp));
    check("misaligned", 64'(mis), 64'(e.mis));
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc     = m_pc;
    e.cnt    = m_cnt;
    e.halted = m_halted;
    e.bp     = m_bp;
    e.mis    = m_mis;
    return e;
  endfunction

  task automatic model_reset();
    m_pc        = RV;
    m_cnt       = 0;
    m_halted    = 0;
    m_bp        = 0;
    m_mis       = 0;
    m_prev_step = 1;
  endtask

  // One falling edge of behaviour, from the rules in plain terms.
  task automatic model_step();
    logic [31:0] t;
    bit          go;
    go = !m_halted && pc_write && (run_mode || (step && !m_prev_step));
    m_bp  = 0;
    m_mis = 0;
    if (restart) begin
      m_pc     = RV;
      m_cnt    = 0;
      m_halted = 0;
    end else if (go) begin
      if (bp_en && m_pc == bp_addr) begin
        m_halted = 1;
        m_bp     = 1;
      end else if (halt) begin
        m_halted = 1;
      end else begin
        if (branch)    t = bt;
        else if (jr)   t = jrt;
        else if (jump) t = jt;
        else           t = m_pc + 4;
        m_mis = (branch || jr || jump) && (t % 4 != 0);
        m_pc  = t - (t % 4);
        m_cnt = m_cnt + 1;
      end
    end
    m_prev_step = step;
  endtask

  task automatic idle();
    branch = 0; jr = 0; jump = 0; halt = 0; restart = 0;
    bt = 0; jrt = 0; jt = 0;
  endtask

  task automatic cyc();
    model_step();
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst_n && exp_q.size() > 0) check_all(exp_q.pop_front());
  end

  initial begin
    idle();
    run_mode = 1; step = 0; pc_write = 1; bp_en = 0; bp_addr = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all(model_snapshot());
    rst_n = 1;

    // sequential run
    repeat (3) cyc();

    // priority and misalignment
    branch = 1; bt = 32'h100; jr = 1; jrt = 32'h300;
    jump = 1; jt = 32'h200;
    cyc();
    idle();
    jump = 1; jt = 32'h203;
    cyc();
    idle();
    cyc();

    // hazard stall holds the jump
    pc_write = 0; jump = 1; jt = 32'h80;
    cyc(); cyc();
    pc_write = 1;
    cyc();
    idle();

    // single-step edges
    run_mode = 0; step = 1;
    repeat (5) cyc();
    step = 0; cyc();
    step = 1; cyc();
    step = 0; cyc();
    run_mode = 1;

    // breakpoint wins over halt, then redirects ignored
    restart = 1; cyc(); restart = 0;
    repeat (2) cyc();
    bp_en = 1; bp_addr = 32'h8; halt = 1;
    cyc();
    halt = 0; jump = 1; jt = 32'h40; branch = 1; bt = 32'h44;
    repeat (3) cyc();
    idle(); bp_en = 0;
    restart = 1; cyc(); restart = 0;
    cyc();

    // async reset while halted at 0x40, then step held across reset
    jump = 1; jt = 32'h40; cyc(); idle();
    halt = 1; cyc(); halt = 0;
    cyc();
    #2;
    rst_n = 0; step = 1; run_mode = 0;
    #1;
    model_reset();
    check_all(model_snapshot());
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) cyc();
    step = 0; cyc();
    run_mode = 1;

    // wrap around top of address space
    jump = 1; jt = 32'hFFFF_FFFC; cyc(); idle();
    repeat (2) cyc();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      run_mode = ($urandom_range(0, 3) != 0);
      step     = 1'($urandom_range(0, 1));
      pc_write = ($urandom_range(0, 4) != 0);
      branch   = ($urandom_range(0, 7) == 0);
      jr       = ($urandom_range(0, 7) == 0);
      jump     = ($urandom_range(0, 7) == 0);
      bt       = $urandom & 32'h3FF;
      jrt      = $urandom & 32'h3FF;
      jt       = $urandom & 32'h3FF;
      halt     = ($urandom_range(0, 19) == 0);
      restart  = ($urandom_range(0, 15) == 0);
      bp_en    = 1'($urandom_range(0, 1));
      bp_addr  = ($urandom_range(0, 7) == 0) ? m_pc : ($urandom & 32'h3FC);
      cyc();
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
